// File: rtl/ram_stream_reader.sv
// Streams a contiguous (wrapping) range of words out of a 1R1W synchronous RAM.
// A 3-entry FIFO plus one-read-in-flight credit hides the RAM read latency.
module ram_stream_reader #(
    parameter int width_p = 8,
    parameter int depth_p = 512
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [$clog2(depth_p)-1:0] cmd_addr_i,
    input  logic [$clog2(depth_p):0]   cmd_len_i,
    output logic                       ram_rd_valid_o,
    output logic [$clog2(depth_p)-1:0] ram_rd_addr_o,
    input  logic [width_p-1:0]         ram_rd_data_i,
    output logic                       data_valid_o,
    input  logic                       data_ready_i,
    output logic [width_p-1:0]         data_o,
    output logic                       data_last_o,
    output logic                       busy_o
);
    localparam int AW = $clog2(depth_p);
    localparam int LW = AW + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      r_last_addr;
    logic [LW-1:0]      r_remaining;
    logic               r_inflight;
    logic               r_inflight_last;
    logic [width_p-1:0] r_fifo_data [3];
    logic [2:0]         r_fifo_last;
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [1:0]         r_count;

    logic               w_credit;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_cmd_fire;
    logic [LW-1:0]      w_len_sat;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign w_credit   = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3;
    assign w_issue    = (r_state == READ) && (r_remaining != '0) && w_credit;
    assign w_push     = r_inflight;
    assign w_pop      = (r_count != 2'd0) && data_ready_i;
    assign w_cmd_fire = cmd_valid_i && cmd_ready_o;
    assign w_len_sat  = (cmd_len_i > LW'(depth_p)) ? LW'(depth_p) : cmd_len_i;

    assign cmd_ready_o    = (r_state == IDLE);
    assign ram_rd_valid_o = w_issue;
    assign ram_rd_addr_o  = w_issue ? r_addr : r_last_addr;
    assign data_valid_o   = (r_count != 2'd0);
    assign data_o         = r_fifo_data[r_rd_ptr];
    assign data_last_o    = data_valid_o && r_fifo_last[r_rd_ptr];
    assign busy_o         = (r_state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_last_addr     <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= 2'd0;
            r_rd_ptr        <= 2'd0;
            r_count         <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_rd_data_i;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LW'(1));
            if (w_issue) begin
                r_last_addr <= r_addr;
                r_addr      <= (r_addr == AW'(depth_p - 1)) ? '0 : r_addr + AW'(1);
                r_remaining <= r_remaining - LW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_cmd_fire && (w_len_sat != '0)) begin
                        r_state     <= READ;
                        r_addr      <= cmd_addr_i;
                        r_remaining <= w_len_sat;
                    end
                end
                READ: begin
                    if (w_issue && (r_remaining == LW'(1))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && data_last_o) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
